freq_phase_meter: RTL and testbench

//   Measures the frequency of sig_a and the phase lag of sig_b relative to sig_a.

---
 rtl/freq_phase_meter.sv | 147 ++++++++++++++
 tb/tb_freq_phase_meter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/freq_phase_meter.sv
// Gated frequency counter for sig_a plus phase lag of sig_b behind sig_a,
// with a serial restoring divider converting delay/period into PHASE_SCALE units.
//
// state  | meaning
// GATE   | count sig_a edges, time the period and the a->b delay
// DIV    | 48-step restoring divide of dt_lat*PHASE_SCALE by per_lat
// UPDATE | publish pinlv/phase, pulse meas_valid, clear the gate counters
module freq_phase_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int PHASE_SCALE = 3600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sig_a,
    input  logic        sig_b,
    output logic [31:0] pinlv,
    output logic [31:0] phase,
    output logic        meas_valid,
    output logic        no_signal
);

    typedef enum logic [1:0] {GATE, DIV, UPDATE} state_t;

    localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);
    localparam logic [47:0] PH_MAX    = 48'(PHASE_SCALE - 1);

    state_t      state;
    logic        a_meta, a_sync, a_prev, rise_a;
    logic        b_meta, b_sync, b_prev, rise_b;
    logic [31:0] gate_cnt, edge_cnt, per_cnt, dt_cnt;
    logic [31:0] per_lat, dt_lat;
    logic        a_seen, b_seen, dt_run, have_meas;
    logic [5:0]  div_cnt;
    logic [47:0] dvd;
    logic [31:0] rem;

    logic [47:0] dvd_in, dvd_nxt;
    logic [31:0] rem_in, rem_diff, rem_nxt;
    logic [32:0] rem_sh;
    logic        q_bit;

    // Identical depth on both paths, so the a->b delay is unbiased.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_meta <= 1'b0; a_sync <= 1'b0; a_prev <= 1'b0; rise_a <= 1'b0;
            b_meta <= 1'b0; b_sync <= 1'b0; b_prev <= 1'b0; rise_b <= 1'b0;
        end else begin
            a_meta <= sig_a;  a_sync <= a_meta;  a_prev <= a_sync;
            rise_a <= a_sync & ~a_prev;
            b_meta <= sig_b;  b_sync <= b_meta;  b_prev <= b_sync;
            rise_b <= b_sync & ~b_prev;
        end
    end

    // One restoring step; the first step loads the dividend directly.
    always_comb begin
        dvd_in   = (div_cnt == 6'd0) ? 48'(dt_lat) * 48'(PHASE_SCALE) : dvd;
        rem_in   = (div_cnt == 6'd0) ? 32'd0 : rem;
        rem_sh   = {rem_in, dvd_in[47]};
        q_bit    = rem_sh >= {1'b0, per_lat};
        rem_diff = rem_sh[31:0] - per_lat;
        rem_nxt  = q_bit ? rem_diff : rem_sh[31:0];
        dvd_nxt  = {dvd_in[46:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= GATE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            per_cnt    <= '0;
            dt_cnt     <= '0;
            per_lat    <= '0;
            dt_lat     <= '0;
            a_seen     <= 1'b0;
            b_seen     <= 1'b0;
            dt_run     <= 1'b0;
            have_meas  <= 1'b0;
            div_cnt    <= '0;
            dvd        <= '0;
            rem        <= '0;
            pinlv      <= '0;
            phase      <= '0;
            meas_valid <= 1'b0;
            no_signal  <= 1'b1;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                GATE: begin
                    gate_cnt <= gate_cnt + 32'd1;
                    if (gate_cnt == GATE_LAST) begin
                        state   <= DIV;
                        div_cnt <= '0;
                    end
                    if (per_cnt != '1) per_cnt <= per_cnt + 32'd1;
                    if (dt_run && dt_cnt != '1) dt_cnt <= dt_cnt + 32'd1;
                    if (rise_b && dt_run) begin
                        dt_run <= 1'b0;
                        b_seen <= 1'b1;
                    end
                    // rise_a wins over the updates above; a coincident rise_b
                    // then closes the new period with zero delay.
                    if (rise_a) begin
                        if (edge_cnt != '1) edge_cnt <= edge_cnt + 32'd1;
                        if (a_seen && b_seen) begin
                            per_lat   <= (per_cnt == '1) ? per_cnt : per_cnt + 32'd1;
                            dt_lat    <= dt_cnt;
                            have_meas <= 1'b1;
                        end
                        a_seen  <= 1'b1;
                        per_cnt <= '0;
                        dt_cnt  <= '0;
                        dt_run  <= ~rise_b;
                        b_seen  <= rise_b;
                    end
                end
                DIV: begin
                    div_cnt <= div_cnt + 6'd1;
                    dvd     <= dvd_nxt;
                    rem     <= rem_nxt;
                    if (div_cnt == 6'd47) state <= UPDATE;
                end
                UPDATE: begin
                    pinlv <= edge_cnt;
                    if (!have_meas || per_lat == 32'd0)
                        phase <= '0;
                    else if (dvd > PH_MAX)
                        phase <= PH_MAX[31:0];
                    else
                        phase <= dvd[31:0];
                    no_signal  <= ~have_meas;
                    meas_valid <= 1'b1;
                    gate_cnt   <= '0;
                    edge_cnt   <= '0;
                    have_meas  <= 1'b0;
                    b_seen     <= 1'b0;
                    dt_run     <= 1'b0;
                    dt_cnt     <= '0;
                    a_seen     <= 1'b0;
                    state      <= GATE;
                end
                default: state <= GATE;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_phase_meter.sv
// Directed bench for freq_phase_meter with a 1000-cycle gate: frequency,
// phase, missing-signal, reset-abort and timing checks.
module tb_freq_phase_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sig_a = 1'b0;
    logic        sig_b = 1'b0;
    logic [31:0] pinlv, phase;
    logic        meas_valid, no_signal;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int a_per = 0, b_per = 0, b_dly = 0;
    int cyc = 0;

    freq_phase_meter #(.GATE_CYCLES(1000), .PHASE_SCALE(3600)) dut (
        .clk(clk), .rst(rst), .sig_a(sig_a), .sig_b(sig_b),
        .pinlv(pinlv), .phase(phase), .meas_valid(meas_valid), .no_signal(no_signal)
    );

    always #5 clk = ~clk;

    // Square-wave generator; sig_b rises b_dly clocks after its period boundary.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            sig_a = (a_per == 0) ? 1'b0 : ((cyc % a_per) < a_per / 2);
            sig_b = (b_per == 0) ? 1'b0 : (((cyc + b_per - b_dly) % b_per) < b_per / 2);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_pulse(input int limit, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (!ok && n < limit) begin
            @(posedge clk); #1;
            n++;
            if (meas_valid) ok = 1'b1;
        end
    endtask

    // Reset, discard the partial first gate, leave the second pulse sampled.
    task automatic settle(input int ap, input int bp, input int bd, output int n2, output bit ok);
        int  n1;
        bit  ok1;
        a_per = ap; b_per = bp; b_dly = bd;
        do_reset();
        wait_pulse(3000, n1, ok1);
        wait_pulse(3000, n2, ok);
        ok = ok & ok1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (pinlv !== 32'd0) $display("FAIL reset_pinlv got %0d want 0", pinlv); else pass_cnt++;
        total_cnt++; if (phase !== 32'd0) $display("FAIL reset_phase got %0d want 0", phase); else pass_cnt++;
        total_cnt++; if (meas_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", meas_valid); else pass_cnt++;
        total_cnt++; if (no_signal !== 1'b1) $display("FAIL reset_nosig got %b want 1", no_signal); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_first_latency();
        int n;
        bit ok;
        a_per = 100; b_per = 100; b_dly = 25;
        do_reset();
        wait_pulse(3000, n, ok);
        total_cnt++; if (!ok || n != 1049) $display("FAIL first_latency got %0d (seen %b) want 1049", n, ok); else pass_cnt++;
    endtask

    task automatic test_phase(input string name, input int bd, input int exp_phase);
        int n;
        bit ok;
        settle(100, 100, bd, n, ok);
        total_cnt++; if (!ok || n != 1049) $display("FAIL %s_period got %0d (seen %b) want 1049", name, n, ok); else pass_cnt++;
        total_cnt++; if (pinlv !== 32'd10) $display("FAIL %s_pinlv got %0d want 10", name, pinlv); else pass_cnt++;
        total_cnt++; if (phase !== 32'(exp_phase)) $display("FAIL %s_phase got %0d want %0d", name, phase, exp_phase); else pass_cnt++;
        total_cnt++; if (no_signal !== 1'b0) $display("FAIL %s_nosig got %b want 0", name, no_signal); else pass_cnt++;
    endtask

    task automatic test_a_low();
        int n;
        bit ok;
        settle(0, 100, 25, n, ok);
        total_cnt++; if (!ok || n != 1049) $display("FAIL alow_period got %0d (seen %b) want 1049", n, ok); else pass_cnt++;
        total_cnt++; if (pinlv !== 32'd0) $display("FAIL alow_pinlv got %0d want 0", pinlv); else pass_cnt++;
        total_cnt++; if (phase !== 32'd0) $display("FAIL alow_phase got %0d want 0", phase); else pass_cnt++;
        total_cnt++; if (no_signal !== 1'b1) $display("FAIL alow_nosig got %b want 1", no_signal); else pass_cnt++;
    endtask

    task automatic test_b_low();
        int n;
        bit ok;
        settle(100, 0, 0, n, ok);
        total_cnt++; if (!ok) $display("FAIL blow_pulse got none want pulse"); else pass_cnt++;
        total_cnt++; if (pinlv !== 32'd10) $display("FAIL blow_pinlv got %0d want 10", pinlv); else pass_cnt++;
        total_cnt++; if (phase !== 32'd0) $display("FAIL blow_phase got %0d want 0", phase); else pass_cnt++;
        total_cnt++; if (no_signal !== 1'b1) $display("FAIL blow_nosig got %b want 1", no_signal); else pass_cnt++;
    endtask

    task automatic test_rst_abort(input string name, input int delay);
        int n;
        bit ok;
        settle(100, 100, 25, n, ok);
        total_cnt++; if (!ok || pinlv !== 32'd10) $display("FAIL %s_pre got %0d want 10", name, pinlv); else pass_cnt++;
        repeat (delay) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++; if (pinlv !== 32'd0) $display("FAIL %s_pinlv got %0d want 0", name, pinlv); else pass_cnt++;
        total_cnt++; if (phase !== 32'd0) $display("FAIL %s_phase got %0d want 0", name, phase); else pass_cnt++;
        total_cnt++; if (no_signal !== 1'b1) $display("FAIL %s_nosig got %b want 1", name, no_signal); else pass_cnt++;
        wait_pulse(3000, n, ok);
        total_cnt++; if (!ok || n != 1049) $display("FAIL %s_latency got %0d (seen %b) want 1049", name, n, ok); else pass_cnt++;
    endtask

    task automatic test_fast();
        int          n;
        bit          ok;
        bit          stable;
        logic [31:0] p0, ph0;
        settle(7, 7, 3, n, ok);
        total_cnt++; if (!ok || pinlv < 32'd142 || pinlv > 32'd143) $display("FAIL fast_pinlv got %0d want 142..143", pinlv); else pass_cnt++;
        total_cnt++; if (phase !== 32'd1542) $display("FAIL fast_phase got %0d want 1542", phase); else pass_cnt++;
        total_cnt++; if (no_signal !== 1'b0) $display("FAIL fast_nosig got %b want 0", no_signal); else pass_cnt++;
        p0 = pinlv;
        ph0 = phase;
        stable = 1'b1;
        for (int i = 0; i < 1048; i++) begin
            @(posedge clk); #1;
            if (meas_valid !== 1'b0 || pinlv !== p0 || phase !== ph0) stable = 1'b0;
        end
        total_cnt++; if (!stable) $display("FAIL fast_stable got change want steady"); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (meas_valid !== 1'b1) $display("FAIL fast_next_pulse got %b want 1", meas_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_first_latency();
        test_phase("d25", 25, 900);
        test_phase("d99", 99, 3564);
        test_phase("d0", 0, 0);
        test_a_low();
        test_b_low();
        test_rst_abort("rst_gate", 500);
        test_rst_abort("rst_div", 1020);
        test_fast();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
